conv_window_sequencer: RTL

//  Sequences one RGB565 frame from the frame buffer into the 3x3 convolution datapath.

---
 rtl/conv_window_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - raster frame reader that feeds three-row pixel columns to the 3x3 convolution stage
// Issues one read per unstalled cycle, tags it through the frame-buffer latency, then joins it with two stored rows.
module conv_window_sequencer #(
   parameter int H_PIXELS     = 240,
   parameter int V_PIXELS     = 320,
   parameter int READ_LATENCY = 2,
   parameter int PIXEL_WIDTH  = 16
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        frame_start_in,
   input  logic                        stall_in,
   output logic [16:0]                 pixel_addr_out,
   output logic                        pixel_en_out,
   input  logic [PIXEL_WIDTH-1:0]      pixel_data_in,
   output logic [2:0][PIXEL_WIDTH-1:0] data_out,
   output logic [7:0]                  hcount_out,
   output logic [8:0]                  vcount_out,
   output logic                        data_valid_out,
   output logic                        busy_out,
   output logic                        frame_done_out
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic       valid;
      logic [7:0] h;
      logic [8:0] v;
      logic [1:0] row;
   } tag_t;

   localparam logic [7:0] H_LAST = 8'(H_PIXELS - 1);
   localparam logic [8:0] V_LAST = 9'(V_PIXELS - 1);

   state_t                        state_q, state_d;
   logic [7:0]                    h_q, h_d;
   logic [8:0]                    v_q, v_d;
   logic [1:0]                    row_q, row_d;
   logic [16:0]                   addr_q, addr_d;
   tag_t                          pipe_q [READ_LATENCY];
   tag_t                          pipe_d [READ_LATENCY];
   logic [2:0][PIXEL_WIDTH-1:0]   data_q, data_d;
   logic [7:0]                    hcount_q, hcount_d;
   logic [8:0]                    vcount_q, vcount_d;
   logic                          valid_q, valid_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;

   logic [PIXEL_WIDTH-1:0]        line_buf [3][H_PIXELS];

   logic                          active;
   logic                          advance;
   logic                          issue;
   logic                          last_issue;
   logic                          pipe_empty;
   tag_t                          head;
   logic [1:0]                    row_m1;
   logic [1:0]                    row_m2;

   assign active     = (state_q == RUN) || (state_q == DRAIN);
   assign advance    = active && !stall_in;
   assign issue      = (state_q == RUN) && !stall_in;
   assign last_issue = issue && (h_q == H_LAST) && (v_q == V_LAST);

   // head is the tag whose read data is on pixel_data_in this cycle
   assign head   = pipe_q[READ_LATENCY-1];
   assign row_m1 = (head.row == 2'd0) ? 2'd2 : head.row - 2'd1;
   assign row_m2 = (head.row == 2'd2) ? 2'd0 : head.row + 2'd1;

   always_comb begin
      pipe_empty = 1'b1;
      for (int i = 0; i < READ_LATENCY; i++) begin
         if (pipe_q[i].valid) pipe_empty = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      v_d      = v_q;
      row_d    = row_q;
      addr_d   = addr_q;
      pipe_d   = pipe_q;
      data_d   = data_q;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_start_in) begin
               state_d = RUN;
               busy_d  = 1'b1;
               h_d     = '0;
               v_d     = '0;
               row_d   = '0;
               addr_d  = '0;
            end
         end
         RUN: begin
            if (last_issue) state_d = DRAIN;
         end
         DRAIN: begin
            // empty pipe now means the output stage empties on this same edge
            if (advance && pipe_empty) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (issue) begin
         addr_d = last_issue ? 17'd0 : addr_q + 17'd1;
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d   = '0;
               row_d = '0;
            end else begin
               v_d   = v_q + 9'd1;
               row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
            end
         end else begin
            h_d = h_q + 8'd1;
         end
      end

      if (advance) begin
         pipe_d[0].valid = issue;
         pipe_d[0].h     = h_q;
         pipe_d[0].v     = v_q;
         pipe_d[0].row   = row_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
         valid_d = head.valid;
         if (head.valid) begin
            data_d[0] = pixel_data_in;
            data_d[1] = (head.v >= 9'd1) ? line_buf[row_m1][head.h] : '0;
            data_d[2] = (head.v >= 9'd2) ? line_buf[row_m2][head.h] : '0;
            hcount_d  = head.h;
            vcount_d  = head.v;
         end
      end
   end

   // line buffers are deliberately not reset; edge rows are masked on read instead
   always_ff @(posedge clk_in) begin
      if (advance && head.valid) begin
         line_buf[head.row][head.h] <= pixel_data_in;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         h_q      <= '0;
         v_q      <= '0;
         row_q    <= '0;
         addr_q   <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
         data_q   <= '0;
         hcount_q <= '0;
         vcount_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         v_q      <= v_d;
         row_q    <= row_d;
         addr_q   <= addr_d;
         pipe_q   <= pipe_d;
         data_q   <= data_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign pixel_en_out   = issue;
   assign pixel_addr_out = addr_q;
   assign data_out       = data_q;
   assign hcount_out     = hcount_q;
   assign vcount_out     = vcount_q;
   assign data_valid_out = valid_q;
   assign busy_out       = busy_q;
   assign frame_done_out = done_q;

endmodule
